// File: rtl/tlb_inst_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tlb_inst_ctrl_pkg : opcode defines, FSM states and limits for tlb_inst_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
`ifndef LSOC1K_TLB_CODE_BIT
`define LSOC1K_TLB_CODE_BIT 5
`define LSOC1K_TLB_TLBWI    5'b00001
`define LSOC1K_TLB_TLBWR    5'b00010
`define LSOC1K_TLB_TLBR     5'b00100
`define LSOC1K_TLB_TLBP     5'b01000
`define LSOC1K_TLB_INVTLB   5'b10000
`endif

package tlb_inst_ctrl_pkg;
   localparam int TLB_CODE_W = `LSOC1K_TLB_CODE_BIT;
   typedef logic [TLB_CODE_W-1:0] tlb_code_t;

   localparam tlb_code_t OP_TLBWI  = `LSOC1K_TLB_TLBWI;
   localparam tlb_code_t OP_TLBWR  = `LSOC1K_TLB_TLBWR;
   localparam tlb_code_t OP_TLBR   = `LSOC1K_TLB_TLBR;
   localparam tlb_code_t OP_TLBP   = `LSOC1K_TLB_TLBP;
   localparam tlb_code_t OP_INVTLB = `LSOC1K_TLB_INVTLB;

   localparam logic [3:0] WDOG_LIMIT = 4'd15;
   localparam logic [4:0] INV_OP_MAX = 5'd6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_WB   = 2'd3
   } state_e;
endpackage
`default_nettype wire

// File: rtl/tlb_inst_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tlb_inst_ctrl_if : EX / TLB / CSR signal bundle around tlb_inst_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
interface tlb_inst_ctrl_if;
   import tlb_inst_ctrl_pkg::*;

   logic        ex_valid;
   tlb_code_t   ex_tlb_op;
   logic [4:0]  ex_inv_op;
   logic [9:0]  ex_inv_asid;
   logic [31:0] ex_inv_vaddr;
   logic        ex_flush;
   logic        ex_stall;
   logic        ex_done;
   logic        ex_ine;
   logic        tlb_req;
   tlb_code_t   tlb_op;
   logic [4:0]  c_op;
   logic [9:0]  inv_asid;
   logic [31:0] invtlb_vaddr;
   logic        tlb_recv;
   logic        tlb_finish;
   logic [31:0] tlb_index_in, tlb_entryhi_in, tlb_entrylo0_in, tlb_entrylo1_in, tlb_asid_in;
   logic        csr_index_we, csr_entryhi_we, csr_entrylo0_we, csr_entrylo1_we, csr_asid_we;
   logic [31:0] csr_index_wd, csr_entryhi_wd, csr_entrylo0_wd, csr_entrylo1_wd, csr_asid_wd;
   logic        tlb_timeout;

   modport slave (
      input  ex_valid, ex_tlb_op, ex_inv_op, ex_inv_asid, ex_inv_vaddr, ex_flush,
      input  tlb_recv, tlb_finish,
      input  tlb_index_in, tlb_entryhi_in, tlb_entrylo0_in, tlb_entrylo1_in, tlb_asid_in,
      output ex_stall, ex_done, ex_ine, tlb_req, tlb_op, c_op, inv_asid, invtlb_vaddr,
      output csr_index_we, csr_entryhi_we, csr_entrylo0_we, csr_entrylo1_we, csr_asid_we,
      output csr_index_wd, csr_entryhi_wd, csr_entrylo0_wd, csr_entrylo1_wd, csr_asid_wd,
      output tlb_timeout
   );

   modport master (
      output ex_valid, ex_tlb_op, ex_inv_op, ex_inv_asid, ex_inv_vaddr, ex_flush,
      output tlb_recv, tlb_finish,
      output tlb_index_in, tlb_entryhi_in, tlb_entrylo0_in, tlb_entrylo1_in, tlb_asid_in,
      input  ex_stall, ex_done, ex_ine, tlb_req, tlb_op, c_op, inv_asid, invtlb_vaddr,
      input  csr_index_we, csr_entryhi_we, csr_entrylo0_we, csr_entrylo1_we, csr_asid_we,
      input  csr_index_wd, csr_entryhi_wd, csr_entrylo0_wd, csr_entrylo1_wd, csr_asid_wd,
      input  tlb_timeout
   );
endinterface
`default_nettype wire

// File: rtl/tlb_inst_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tlb_inst_ctrl : sequences one EX-stage TLB instruction through the TLB
// Revision 1.0
// ---------------------------------------------------------------------------
module tlb_inst_ctrl
   import tlb_inst_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   tlb_inst_ctrl_if.slave bus
);
   state_e      state_q, state_d;
   tlb_code_t   op_q;
   logic [4:0]  cop_q;
   logic [9:0]  asid_q;
   logic [31:0] vaddr_q;
   logic        kill_q;
   logic [3:0]  wdog_q;
   logic [31:0] index_wd_q, entryhi_wd_q, entrylo0_wd_q, entrylo1_wd_q, asid_wd_q;

   logic w_legal, w_inv_bad, w_accept, w_expired, w_kill, w_wb_ok;

   assign w_legal   = (bus.ex_tlb_op == OP_TLBWI) || (bus.ex_tlb_op == OP_TLBWR) ||
                      (bus.ex_tlb_op == OP_TLBR)  || (bus.ex_tlb_op == OP_TLBP)  ||
                      (bus.ex_tlb_op == OP_INVTLB);
   assign w_inv_bad = (bus.ex_tlb_op == OP_INVTLB) && (bus.ex_inv_op > INV_OP_MAX);
   assign w_accept  = (state_q == S_IDLE) && bus.ex_valid && !bus.ex_flush &&
                      w_legal && !w_inv_bad;
   assign w_expired = (state_q == S_WAIT) && !bus.tlb_finish && (wdog_q == WDOG_LIMIT);
   // A flush in the WB cycle itself must already suppress the write-back
   assign w_kill    = kill_q || bus.ex_flush;
   assign w_wb_ok   = (state_q == S_WB) && !w_kill;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         op_q          <= '0;
         cop_q         <= '0;
         asid_q        <= '0;
         vaddr_q       <= '0;
         kill_q        <= 1'b0;
         wdog_q        <= '0;
         index_wd_q    <= '0;
         entryhi_wd_q  <= '0;
         entrylo0_wd_q <= '0;
         entrylo1_wd_q <= '0;
         asid_wd_q     <= '0;
      end else begin
         state_q <= state_d;
         if (w_accept) begin
            op_q    <= bus.ex_tlb_op;
            cop_q   <= bus.ex_inv_op;
            asid_q  <= bus.ex_inv_asid;
            vaddr_q <= bus.ex_inv_vaddr;
         end
         if (state_q == S_REQ)
            wdog_q <= '0;
         else if (state_q == S_WAIT)
            wdog_q <= wdog_q + 4'd1;
         if (state_q == S_IDLE)
            kill_q <= 1'b0;
         else if ((state_q == S_WAIT) || (state_q == S_WB))
            kill_q <= w_kill;
         if ((state_q == S_WAIT) && bus.tlb_finish) begin
            index_wd_q    <= bus.tlb_index_in;
            entryhi_wd_q  <= bus.tlb_entryhi_in;
            entrylo0_wd_q <= bus.tlb_entrylo0_in;
            entrylo1_wd_q <= bus.tlb_entrylo1_in;
            asid_wd_q     <= bus.tlb_asid_in;
         end
      end
   end

   always_comb begin
      state_d             = state_q;
      bus.ex_stall        = (state_q != S_IDLE);
      bus.tlb_req         = (state_q == S_REQ);
      bus.ex_ine          = (state_q == S_IDLE) && bus.ex_valid && !bus.ex_flush && w_inv_bad;
      bus.ex_done         = w_wb_ok;
      bus.tlb_timeout     = w_expired;
      bus.csr_index_we    = w_wb_ok && ((op_q == OP_TLBP) || (op_q == OP_TLBR));
      bus.csr_entryhi_we  = w_wb_ok && (op_q == OP_TLBR);
      bus.csr_entrylo0_we = w_wb_ok && (op_q == OP_TLBR);
      bus.csr_entrylo1_we = w_wb_ok && (op_q == OP_TLBR);
      bus.csr_asid_we     = w_wb_ok && (op_q == OP_TLBR);
      case (state_q)
         S_IDLE:  if (w_accept) state_d = S_REQ;
         S_REQ:   if (bus.tlb_recv) state_d = S_WAIT;
                  else if (bus.ex_flush) state_d = S_IDLE;
         S_WAIT:  if (bus.tlb_finish) state_d = S_WB;
                  else if (w_expired) state_d = S_IDLE;
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.tlb_op         = op_q;
   assign bus.c_op           = cop_q;
   assign bus.inv_asid       = asid_q;
   assign bus.invtlb_vaddr   = vaddr_q;
   assign bus.csr_index_wd   = index_wd_q;
   assign bus.csr_entryhi_wd = entryhi_wd_q;
   assign bus.csr_entrylo0_wd = entrylo0_wd_q;
   assign bus.csr_entrylo1_wd = entrylo1_wd_q;
   assign bus.csr_asid_wd    = asid_wd_q;
endmodule
`default_nettype wire

// File: doc/tlb_inst_ctrl.md
TLB_INST_CTRL -- requirements
Module: tlb_inst_ctrl

Interface
REQ-001 The block SHALL have these ports; reset is synchronous and active-high, and the clock is clk:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ex_valid  in  1  TLB instruction present in EX
- ex_tlb_op  in  `LSOC1K_TLB_CODE_BIT  decoded TLB opcode (TLBWI/TLBWR/TLBR/TLBP/INVTLB)
- ex_inv_op  in  5  INVTLB op field
- ex_inv_asid  in  10  INVTLB ASID operand
- ex_inv_vaddr  in  32  INVTLB VA operand
- ex_flush  in  1  pipeline kill of the EX instruction
- ex_stall  out  1  hold EX
- ex_done  out  1  one-cycle completion pulse
- ex_ine  out  1  one-cycle illegal-instruction pulse (bad INVTLB op)
- tlb_req  out  1  request to TLB
- tlb_op  out  `LSOC1K_TLB_CODE_BIT  registered opcode
- c_op  out  5  registered INVTLB op
- inv_asid  out  10  registered INVTLB ASID
- invtlb_vaddr  out  32  registered INVTLB VA
- tlb_recv  in  1  TLB accepted request
- tlb_finish  in  1  TLB operation finished (1-cycle pulse)
- tlb_index_in, tlb_entryhi_in, tlb_entrylo0_in, tlb_entrylo1_in, tlb_asid_in  in  32 each  TLB result values
- csr_index_we, csr_entryhi_we, csr_entrylo0_we, csr_entrylo1_we, csr_asid_we  out  1 each  CSR write enables
- csr_index_wd, csr_entryhi_wd, csr_entrylo0_wd, csr_entrylo1_wd, csr_asid_wd  out  32 each  CSR write data
- tlb_timeout  out  1  one-cycle watchdog error pulse

Function
REQ-002 The FSM SHALL have exactly four states: IDLE, REQ, WAIT, WB.
REQ-003 In IDLE, when ex_valid=1, ex_flush=0 and the opcode is legal, the block SHALL register opcode and operands and move to REQ on the next edge.
REQ-004 INVTLB with ex_inv_op>6 SHALL pulse ex_ine for one cycle, stay in IDLE, and issue no request.
REQ-005 tlb_req SHALL be 1 exactly while in REQ, and tlb_op/c_op/inv_asid/invtlb_vaddr SHALL stay stable from REQ entry until return to IDLE.
REQ-006 In REQ, tlb_recv=1 SHALL move the FSM to WAIT; without tlb_recv it SHALL stay in REQ indefinitely.
REQ-007 In REQ, ex_flush=1 with tlb_recv=0 SHALL return the FSM to IDLE next cycle and drop tlb_req. ex_flush together with tlb_recv SHALL be treated as accepted (go to WAIT).
REQ-008 In WAIT, tlb_finish=1 SHALL capture all five tlb_*_in values into the wd registers and move to WB.
REQ-009 A 4-bit watchdog SHALL clear on WAIT entry and increment each WAIT cycle; finish absent when the count reaches 15 SHALL pulse tlb_timeout and return to IDLE with no CSR write and no ex_done.
REQ-010 WB SHALL last exactly one cycle, pulse ex_done, and assert write enables by opcode:
- TLBP: index only
- TLBR: index, entryhi, entrylo0, entrylo1, asid
- TLBWI, TLBWR, INVTLB: none
REQ-011 ex_flush seen at any point from WAIT entry through WB SHALL set a sticky kill bit; with kill set, WB SHALL suppress write enables and ex_done. The kill bit SHALL clear in IDLE.
REQ-012 ex_stall SHALL be 1 in REQ, WAIT and WB, and 0 in IDLE.
REQ-013 tlb_finish arriving outside WAIT SHALL be ignored.
REQ-014 Minimum latency from ex_valid to ex_done SHALL be 4 cycles when recv arrives in the first REQ cycle and finish 2 cycles later.

Reset
REQ-015 reset SHALL force IDLE and zero all outputs, wd registers, the kill bit and the watchdog, including during an operation in flight.

Structure
REQ-016 State encoding, the watchdog limit (15) and the max INVTLB op (6) SHALL live in the shared package. Opcode constants SHALL come from the existing shared defines.
REQ-017 The block SHALL be a single module with no sub-module.

Verification
REQ-018 TLBR, recv in the first REQ cycle, finish 2 cycles later with index=0x0C000003 -> all 5 WEs=1 for one cycle, csr_index_wd=0x0C000003, ex_done at cycle 4.
REQ-019 TLBP, recv delayed 3 cycles -> tlb_req held for 4 cycles with a stable opcode; only csr_index_we=1.
REQ-020 INVTLB op=7 -> ex_ine pulse, tlb_req never asserted. INVTLB op=5 with asid=0x2A -> c_op=5, inv_asid=0x2A, no WEs.
REQ-021 Flush in REQ before recv -> IDLE next cycle. Flush in WAIT -> finish consumed, no WEs, no ex_done.
REQ-022 TLBWI with finish never arriving -> tlb_timeout pulse after 15 WAIT cycles, then IDLE.
REQ-023 Reset asserted in WAIT -> next cycle IDLE with all outputs 0.
